// File: rtl/pe_vec_reduce.sv
// pe_vec_reduce: multi-lane signed processing element for the softmax datapath.
// Each lane runs one of three operations, picked per packet by mode:
//   ADD (00, and the reserved 11): r = in1 + in2 on every beat, one result per beat.
//   SUM (01): sum of (in1 + in2) over the whole packet.
//   MAX (10): maximum of in1 over the whole packet.
// A valid/ready handshake on each side, with one registered output stage.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-high (1 = reset)
//   mode       operation select, sampled on the first beat of a packet
//   in_valid   input beat valid
//   in_ready   block can accept a beat (combinational: ~out_valid | out_ready)
//   in_last    last beat of a SUM/MAX packet; ignored in ADD
//   in1, in2   packed lane operands, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   packed per-lane result, same packing as in1
//   out_count  number of beats folded into out_data (saturates at all-ones)
//
// Build option: define PE_SAT_EN to clamp results into the signed DATA_WIDTH
// range; otherwise results wrap to the low DATA_WIDTH bits.

module pe_vec_reduce #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in1,
    input  logic [LANES*DATA_WIDTH-1:0] in2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]        out_count
);

    localparam int unsigned ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
    localparam int unsigned BUS_WIDTH = LANES * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_SUM = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

`ifdef PE_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(CNT_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(CNT_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]                  mode_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0]        cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q [LANES];
    logic signed [ACC_WIDTH-1:0] acc_d [LANES];
    logic signed [ACC_WIDTH-1:0] op_a  [LANES];
    logic signed [ACC_WIDTH-1:0] op_b  [LANES];
    logic signed [ACC_WIDTH-1:0] beat_sum [LANES];
    logic signed [ACC_WIDTH-1:0] result   [LANES];
    logic [BUS_WIDTH-1:0]        data_d;

    logic       in_fire;
    logic       first_beat;
    logic [1:0] mode_eff;
    logic       is_sum;
    logic       is_max;
    logic       is_add;
    logic       emit;

    // Narrow an accumulator-width value to a DATA_WIDTH lane result.
    function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] x);
`ifdef PE_SAT_EN
        if (x > SAT_HI) begin
            return SAT_HI[DATA_WIDTH-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[DATA_WIDTH-1:0];
        end else begin
            return x[DATA_WIDTH-1:0];
        end
`else
        return x[DATA_WIDTH-1:0];
`endif
    endfunction

    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;

    // Decode, per-lane arithmetic and next-state logic.
    always_comb begin
        state_d    = state_q;
        first_beat = (state_q == S_IDLE);
        // Inside a packet the mode latched on its first beat is authoritative.
        mode_eff   = first_beat ? mode : mode_q;
        is_sum     = (mode_eff == MODE_SUM);
        is_max     = (mode_eff == MODE_MAX);
        is_add     = ~is_sum & ~is_max;
        emit       = in_fire & (is_add | in_last);
        data_d     = '0;

        if (first_beat) begin
            cnt_d = CNT_WIDTH'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        for (int k = 0; k < LANES; k++) begin
            op_a[k] = ACC_WIDTH'(signed'(in1[k*DATA_WIDTH +: DATA_WIDTH]));
            op_b[k] = ACC_WIDTH'(signed'(in2[k*DATA_WIDTH +: DATA_WIDTH]));
            // Sign-extended at ACC_WIDTH this is exactly the DATA_WIDTH+1 bit sum.
            beat_sum[k] = op_a[k] + op_b[k];

            if (is_max) begin
                acc_d[k] = (first_beat || (op_a[k] > acc_q[k])) ? op_a[k] : acc_q[k];
            end else begin
                acc_d[k] = first_beat ? beat_sum[k] : (acc_q[k] + beat_sum[k]);
            end

            result[k] = is_add ? beat_sum[k] : acc_d[k];
            data_d[k*DATA_WIDTH +: DATA_WIDTH] = narrow(result[k]);
        end

        if (in_fire && !is_add) begin
            state_d = in_last ? S_IDLE : S_ACCUM;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet context: latched mode, accumulators and beat counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_q <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
        end else if (in_fire) begin
            if (first_beat) begin
                mode_q <= mode;
            end
            if (!is_add) begin
                cnt_q <= cnt_d;
                for (int k = 0; k < LANES; k++) begin
                    acc_q[k] <= acc_d[k];
                end
            end
        end
    end

    // Output stage: loads on an emitting beat, holds under backpressure.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= data_d;
            out_count <= is_add ? CNT_WIDTH'(1) : cnt_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
